// File: rtl/key_expand_128_if.sv
// Round-key handshake bundle between the key schedule and the round datapath.
// slave = key schedule side, master = consumer/driver side.
interface key_expand_128_if;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] round_key;
  logic         rk_valid;
  logic [3:0]   round_num;
  logic         rk_last;
  logic         busy;

  modport slave (
    input  start, key_in, rk_ready,
    output round_key, rk_valid, round_num, rk_last, busy
  );

  modport master (
    output start, key_in, rk_ready,
    input  round_key, rk_valid, round_num, rk_last, busy
  );
endinterface

// File: rtl/key_expand_128.sv
// AES-128 key expansion: presents round keys 0..10 one per accepted transfer.
// Latency: key 0 one cycle after start; next key one cycle after each transfer; rk_ready low holds the key.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX[a_i];
endmodule

module key_expand_128 (
  input  logic             clk,
  input  logic             reset,
  key_expand_128_if.slave  kif
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         last_q, last_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;
  logic         xfer;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.a_i(rot_w3[31:24]), .s_o(sub_w3[31:24]));
  aes_sbox u_sbox1 (.a_i(rot_w3[23:16]), .s_o(sub_w3[23:16]));
  aes_sbox u_sbox2 (.a_i(rot_w3[15:8]),  .s_o(sub_w3[15:8]));
  aes_sbox u_sbox3 (.a_i(rot_w3[7:0]),   .s_o(sub_w3[7:0]));

  assign t        = sub_w3 ^ {rcon_q, 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // xtime in GF(2^8): 0x80 wraps to 0x1b, giving ...80,1b,36
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  assign xfer = (state_q == ISSUE) && kif.rk_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          state_d = ISSUE;
          key_d   = kif.key_in;
          round_d = 4'd0;
          rcon_d  = 8'h01;
          last_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (xfer) begin
          if (round_q == 4'd10) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
            rcon_d  = rcon_next;
            last_d  = (round_q == 4'd9);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      last_q  <= last_d;
    end
  end

  assign kif.round_key = key_q;
  assign kif.rk_valid  = (state_q == ISSUE);
  assign kif.round_num = round_q;
  assign kif.rk_last   = last_q;
  assign kif.busy      = (state_q != IDLE);
endmodule

// File: doc/key_expand_128.md
# key_expand_128

AES-128 round-key generator that sits directly downstream of the round sequencing in the AES-128 datapath. It expands a 128-bit cipher key into the 11 round keys (rounds 0–10) per FIPS-197, one key per accepted transfer. Keys are presented to the round datapath over a valid/ready handshake, so the datapath can stall the schedule without losing a key.

## Interface
Parameters:
- none. Key size is fixed at 128 bits and Nr at 10.

Ports:
- clk  input  1  — single clock, rising edge.
- reset  input  1  — asynchronous, active-low. Low clears all state immediately. Deassertion is synchronous to clk.
- start  input  1  — load request; sampled only in IDLE.
- key_in  input  128  — cipher key, big-endian bytes (byte 0 = [127:120]); sampled on the accepted start edge only.
- rk_ready  input  1  — consumer can accept round_key this cycle.
- round_key  output  128  — current round key, same byte order as key_in.
- rk_valid  output  1  — round_key and round_num are valid.
- round_num  output  4  — index of the presented key, 0..10.
- rk_last  output  1  — high with rk_valid when round_num == 10.
- busy  output  1  — high in any state other than IDLE.

## Operation
- State machine: IDLE, ISSUE.
- IDLE:
  - start=1 loads key_in into the key register, sets round_num=0 and rcon=8'h01, and moves to ISSUE.
  - start=0 stays in IDLE.
- ISSUE:
  - rk_valid=1 and round_key = key register.
  - Transfer occurs on any edge with rk_valid & rk_ready.
  - Transfer with round_num < 10: key register ← next key, round_num +1, rcon ← xtime(rcon) (reduction polynomial 8'h1b).
  - Transfer with round_num == 10: go to IDLE and clear rk_valid.
  - rk_ready=0: hold round_key, round_num and rcon unchanged.
- Next-key computation (combinational from the key register w0..w3, w0 = [127:96]):
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - SubWord is the FIPS-197 S-box on each byte; the team S-box module is reused, 4 instances.
- rcon sequence per issued key 1..10: 01,02,04,08,10,20,40,80,1b,36.
- start while busy=1 is ignored; the schedule is not restarted and key_in is not resampled.
- key_in changes after the load edge have no effect.
- Reset values:
  - State = IDLE, round_key = 0, round_num = 0, rk_valid = 0, rk_last = 0, busy = 0.
  - rcon = 8'h01.
- Reset asserted mid-schedule aborts at once. The next schedule needs a fresh start.

## Timing
- Start accepted on edge E: rk_valid=1, round_num=0 and round_key=key_in are visible from E+1.
- With rk_ready held at 1:
  - One key per cycle, round_num 0..10 over cycles E+1..E+11.
  - rk_valid=0 and busy=0 from E+12.
  - A new start can be accepted at E+12, giving minimum 12 cycles per key schedule.
- Round-key latency after a transfer is one cycle. No combinational path from rk_ready to rk_valid or round_key.
- rk_last is registered and coincides exactly with the round_num==10 beat.
- busy rises on E+1 and falls on the edge that transfers round 10.
- All outputs are registered. The S-box/XOR path is register-to-register and must close in one cycle.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 2 = f2c295f27a96b9435935807a7359f67f.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1.
  - busy=0 at E+12.
- Same key, rk_ready toggled pseudo-randomly (≥30% low) → identical 11-key sequence. round_key and round_num are stable through every stall; exactly 11 transfers.
- Key all-zero → round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start pulsed during round 4 with a different key_in → sequence continues unaltered through round 10.
- Reset asserted at round 6 → all outputs are reset values in the same cycle. Subsequent start with the FIPS key → round 0 is correct and the rcon sequence restarts at 01.
- Back-to-back schedules: start at E+12 with a new key → rk_valid drops for exactly one cycle (E+12). The second sequence is correct from E+13.
